// File: rtl/buffer_sequencer.sv
// rtl/buffer_sequencer.sv - ping-pong bank sequencer: swaps banks on frame start, streams one bank per frame
module buffer_sequencer #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrDone,
  input  logic          frameStrobe,
  input  logic [11:0]   rdData,
  input  logic          outReady,
  output logic          bufSwitch,
  output logic [AW-1:0] rdAdr,
  output logic          rdBank,
  output logic          rdEn,
  output logic [11:0]   outData,
  output logic          outValid,
  output logic          frameDone,
  output logic          overrun,
  output logic          underrun
);

  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic          buf_ready;
  logic [AW-1:0] adr, adr_nxt;
  logic [CW-1:0] lat_cnt;
  logic          start, swap, capture, handshake, last;

  always_comb begin
    state_nxt = state;
    adr_nxt   = adr;
    start     = 1'b0;
    swap      = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (frameStrobe) begin
          start     = 1'b1;
          swap      = buf_ready;
          adr_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      // lat_cnt counts the ISSUE cycle as 0, so data is valid when it reaches RD_LAT
      WAIT: begin
        if (lat_cnt == CW'(RD_LAT)) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (outReady) begin
          handshake = 1'b1;
          if (adr == AW'(DEPTH - 1)) begin
            last      = 1'b1;
            adr_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            adr_nxt   = adr + AW'(1);
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      buf_ready <= 1'b0;
      bufSwitch <= 1'b0;
      adr       <= '0;
      lat_cnt   <= '0;
      outData   <= '0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      adr   <= adr_nxt;
      if (state == ISSUE)
        lat_cnt <= CW'(1);
      else if (state == WAIT)
        lat_cnt <= lat_cnt + CW'(1);
      if (capture)
        outData <= rdData;
      if (swap)
        bufSwitch <= ~bufSwitch;
      // a wrDone coinciding with a swap refills the pending slot the swap just emptied
      if (wrDone)
        buf_ready <= 1'b1;
      else if (swap)
        buf_ready <= 1'b0;
      overrun   <= wrDone & buf_ready & ~swap;
      underrun  <= start & ~buf_ready;
      frameDone <= handshake & last;
    end
  end

  assign rdEn     = (state == ISSUE);
  assign outValid = (state == HOLD);
  assign rdAdr    = adr;
  assign rdBank   = ~bufSwitch;

endmodule

// File: tb/tb_buffer_sequencer.sv
// tb/tb_buffer_sequencer.sv - directed frame-level bench for buffer_sequencer with a fixed-latency RAM model
module tb_buffer_sequencer;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, wrDone, frameStrobe, outReady;
  logic [11:0] rdData;
  logic        bufSwitch, rdBank, rdEn, outValid, frameDone, overrun, underrun;
  logic [9:0]  rdAdr;
  logic [11:0] outData;

  int n_pass  = 0;
  int n_total = 0;

  logic sw  = 1'b0;
  logic rdy = 1'b0;

  buffer_sequencer #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .wrDone(wrDone), .frameStrobe(frameStrobe),
    .rdData(rdData), .outReady(outReady), .bufSwitch(bufSwitch), .rdAdr(rdAdr),
    .rdBank(rdBank), .rdEn(rdEn), .outData(outData), .outValid(outValid),
    .frameDone(frameDone), .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ram_word(input logic bank, input logic [9:0] adr);
    return (12'({2'b00, adr}) * 12'd5) ^ (bank ? 12'h7a3 : 12'h15c);
  endfunction

  // RAM: data for an rdEn in cycle c appears in cycle c+RD_LAT; garbage otherwise
  logic [11:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= rdEn ? ram_word(rdBank, rdAdr) : 12'hbad;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rdData = pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, {bufSwitch, rdBank, rdEn, outValid, frameDone, overrun, underrun},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check({tag, "_adr"}, rdAdr, 10'd0);
    check({tag, "_data"}, outData, 12'd0);
  endtask

  task automatic pulse_wr();
    wrDone = 1'b1;
    @(negedge clk);
    wrDone = 1'b0;
    check("overrun_pulse", overrun, rdy);
    rdy = 1'b1;
  endtask

  task automatic frame(input string tag, input bit simul_wr, input int stall_word,
                       input int stall_len, input int abort_word);
    logic        exp_under, bank;
    logic [11:0] word;
    int          bad, stall_bad, quiet_bad;
    exp_under = ~rdy;
    if (rdy) begin
      sw  = ~sw;
      rdy = 1'b0;
    end
    if (simul_wr) rdy = 1'b1;
    bank = ~sw;
    frameStrobe = 1'b1;
    wrDone      = simul_wr;
    @(negedge clk);
    frameStrobe = 1'b0;
    wrDone      = 1'b0;
    check({tag, "_start"}, {bufSwitch, underrun, overrun}, {sw, exp_under, 1'b0});
    bad = 0;
    for (int w = 0; w < DEPTH; w++) begin
      check($sformatf("%s_issue%0d", tag, w), {rdEn, outValid, rdBank, rdAdr},
            {1'b1, 1'b0, bank, 10'(w)});
      for (int k = 0; k < RD_LAT; k++) begin
        @(negedge clk);
        if (rdEn || outValid || underrun || overrun || frameDone) bad++;
      end
      @(negedge clk);
      word = ram_word(bank, 10'(w));
      check($sformatf("%s_word%0d", tag, w), {outValid, outData}, {1'b1, word});
      if (w == abort_word) begin
        reset = 1'b1; wrDone = 1'b1; frameStrobe = 1'b1;
        @(negedge clk);
        reset = 1'b0; wrDone = 1'b0; frameStrobe = 1'b0;
        check_reset_state({tag, "_abort"});
        sw  = 1'b0;
        rdy = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (frameDone || rdEn || outValid || underrun || overrun) quiet_bad++;
        end
        check({tag, "_abort_quiet"}, quiet_bad, 0);
        check({tag, "_quiet"}, bad, 0);
        return;
      end
      if (w == stall_word) begin
        outReady  = 1'b0;
        stall_bad = 0;
        for (int s = 0; s < stall_len; s++) begin
          if (s == 10 || s == 30) frameStrobe = 1'b1;
          @(negedge clk);
          frameStrobe = 1'b0;
          if ({outValid, outData, rdAdr, rdEn, underrun, overrun, bufSwitch} !==
              {1'b1, word, 10'(w), 1'b0, 1'b0, 1'b0, sw}) stall_bad++;
        end
        check({tag, "_stall"}, stall_bad, 0);
        outReady = 1'b1;
      end
      @(negedge clk);
      if (w == DEPTH - 1) begin
        check({tag, "_done"}, {frameDone, outValid, rdEn, rdAdr}, {1'b1, 1'b0, 1'b0, 10'd0});
        @(negedge clk);
        check({tag, "_done_once"}, {frameDone, rdEn}, 2'b00);
      end else if (frameDone || underrun || overrun) begin
        bad++;
      end
    end
    check({tag, "_quiet"}, bad, 0);
  endtask

  initial begin
    int ov_cnt;
    reset = 1'b1; wrDone = 1'b0; frameStrobe = 1'b0; outReady = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    // normal swap, then repeat of the same bank
    pulse_wr();
    frame("swap", 0, -1, 0, -1);
    frame("repeat", 0, -1, 0, -1);

    // two fills with no frame in between: one overrun only
    pulse_wr();
    ov_cnt = 0;
    repeat (9) begin
      @(negedge clk);
      if (overrun) ov_cnt++;
    end
    pulse_wr();
    repeat (5) begin
      @(negedge clk);
      if (overrun) ov_cnt++;
    end
    check("overrun_extra", ov_cnt, 0);
    frame("after_ovr", 0, -1, 0, -1);
    frame("after_ovr_rep", 0, -1, 0, -1);

    // swap and fill in the same cycle
    pulse_wr();
    frame("simul", 1, -1, 0, -1);
    frame("simul_next", 0, -1, 0, -1);

    // backpressure on word 5
    pulse_wr();
    frame("stall", 0, 5, 50, -1);

    // reset mid-frame, then a frame from the reset bank
    pulse_wr();
    frame("abort", 0, -1, 0, 300);
    frame("post_reset", 0, -1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/buffer_sequencer.md
BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

Interface
REQ-001 Parameter DEPTH, default 1024: words per bank; read addresses run 0..DEPTH-1.
REQ-002 Parameter RD_LAT, default 2: RAM read latency in clocks, from rdEn to valid rdData.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wrDone  input  1  one-clock pulse from the writer: active bank completely filled.
REQ-006 frameStrobe  input  1  one-clock pulse from the transmitter: start emitting one frame.
REQ-007 rdData  input  12  RAM read data.
REQ-008 outReady  input  1  downstream accepts outData.
REQ-009 bufSwitch  output  1  write-bank select to the writer; the read bank is ~bufSwitch.
REQ-010 rdAdr  output  10  RAM read address within the read bank.
REQ-011 rdBank  output  1  RAM read bank, always equal to ~bufSwitch.
REQ-012 rdEn  output  1  RAM read strobe.
REQ-013 outData  output  12  frame word.
REQ-014 outValid  output  1  outData valid.
REQ-015 frameDone  output  1  one-clock pulse after the last word of a frame is accepted.
REQ-016 overrun  output  1  one-clock pulse: wrDone arrived while a filled bank was still pending.
REQ-017 underrun  output  1  one-clock pulse: frame started with no new bank, so the old bank is repeated.

Function
REQ-018 States are IDLE, ISSUE, WAIT, HOLD and the pending flag bufReady; the FSM is always in exactly one state.
REQ-019 wrDone sets bufReady in any state.
REQ-020 wrDone while bufReady=1, with no swap in the same cycle: pulse overrun next cycle; bufReady stays 1; no other change.
REQ-021 IDLE, frameStrobe=1, bufReady=1: toggle bufSwitch next cycle; clear bufReady; go to ISSUE with rdAdr=0.
REQ-022 IDLE, frameStrobe=1, bufReady=0: bufSwitch unchanged; pulse underrun; go to ISSUE with rdAdr=0.
REQ-023 Swap and wrDone in the same cycle: the swap consumes the old pending bank, bufReady ends at 1, and overrun is not pulsed.
REQ-024 ISSUE: assert rdEn for exactly one cycle with the current rdAdr and rdBank, then go to WAIT.
REQ-025 WAIT: count RD_LAT cycles, with the ISSUE cycle as cycle 0.
REQ-026 WAIT, cycle RD_LAT: capture rdData into outData, set outValid next cycle, and go to HOLD.
REQ-027 HOLD: keep outValid and outData stable until outValid&outReady.
REQ-028 Handshake cycle: clear outValid on the next cycle.
REQ-029 Handshake, rdAdr<DEPTH-1: increment rdAdr and go to ISSUE.
REQ-030 Handshake, rdAdr=DEPTH-1: pulse frameDone, reset rdAdr to 0, and return to IDLE with no wrap to the next frame.
REQ-031 Latency: frameStrobe in cycle t gives the first rdEn in cycle t+1 and outValid high from cycle t+2+RD_LAT.
REQ-032 Word-to-word period is RD_LAT+2 cycles with outReady held high.
REQ-033 frameStrobe outside IDLE is ignored: no state change and no pulse.
REQ-034 bufSwitch changes only on IDLE->ISSUE transitions; rdBank never changes within a frame.
REQ-035 rdEn is asserted only in ISSUE; it is never asserted in IDLE, WAIT or HOLD.
REQ-036 Whenever outValid is high, outData equals RAM content at {rdBank, rdAdr}.

Reset
REQ-037 reset=1 on a clk edge forces these registers next cycle: IDLE, bufReady=0, bufSwitch=0, rdAdr=0, outData=0.
REQ-038 The same reset edge forces all strobes to 0: rdEn, outValid, frameDone, overrun and underrun.
REQ-039 Reset mid-frame abandons the frame without frameDone; the first frame after reset reads bank 1 unless a swap occurs.
REQ-040 Reset has priority over wrDone and frameStrobe in the same cycle.

Verification
REQ-041 Normal swap, RD_LAT=2: wrDone, then frameStrobe at t, outReady=1 -> bufSwitch 0->1 at t+1, rdEn t+1 rdAdr=0 rdBank=0, outValid at t+4, 1024 words at 4-cycle period, frameDone once, overrun=underrun=0.
REQ-042 Repeat: frameStrobe with bufReady=0 -> underrun pulse, bufSwitch unchanged, same 1024 words as the previous frame.
REQ-043 Overrun: two wrDone 10 cycles apart with no frameStrobe -> exactly one overrun pulse; the next frameStrobe swaps once and clears bufReady.
REQ-044 Simultaneous: wrDone and frameStrobe in the same IDLE cycle with bufReady=1 -> swap, bufReady=1 afterwards, no overrun; the next frameStrobe swaps again.
REQ-045 Backpressure: outReady=0 for 50 cycles on word 5 -> outValid held, outData and rdAdr stable, no extra rdEn, frameStrobe pulses during the frame ignored.
REQ-046 Reset at word 300 -> all outputs at reset values next cycle, no frameDone; the next frame starts at rdAdr=0 with bufSwitch=0.
